dpram_stream_reader: RTL and testbench
======================================

// Module: dpram_stream_reader
// PURPOSE
// - Read-side controller for a dpram instance in the same clock domain.
// - On a start request, reads start_len words beginning at start_addr.
// - Hides the RAM's one-cycle registered read latency.
// - Presents the words as a valid/ready stream with a last flag.
// - Sits between a video/line buffer RAM and its consumer (e.g. composer or serialiser).
// PARAMETERS
// - ADDR_WIDTH  8                 RAM address width; must match the attached dpram.
// - DATA_WIDTH  8                 RAM word width; must match the attached dpram.
// - LEN_WIDTH   ADDR_WIDTH+1      Width of start_len; allows a full-RAM burst.
// PORTS
// - clk         in   1            Single clock; the RAM rd_clk is tied to this clock.
// - rst         in   1            Reset; asynchronous, active-high.
// - start       in   1            Pulse: begin a burst. Ignored while busy=1.
// - start_addr  in   ADDR_WIDTH   First address of the burst; sampled with start.
// - start_len   in   LEN_WIDTH    Word count of the burst; sampled with start.
// - abort       in   1            Synchronous flush of the current burst.
// - busy        out  1            Burst in progress.
// - done        out  1            One-cycle pulse: burst completed normally.
// - rd_addr     out  ADDR_WIDTH   Registered; drives dpram rd_addr.
// - rd_data     in   DATA_WIDTH   From dpram rd_data; valid one cycle after rd_addr.
// - out_valid   out  1            Stream word available.
// - out_data    out  DATA_WIDTH   Stream word.
// - out_last    out  1            Marks the final word of the burst.
// - out_ready   in   1            Consumer accepts the word when out_valid & out_ready.
// BEHAVIOUR
// - Reset values: busy=0, done=0, rd_addr=0, out_valid=0, out_data=0, out_last=0.
//   Reset also clears the FIFO and the in-flight tracking. Reset mid-burst drops the
//   burst silently (no done pulse).
// - States: IDLE, RUN, DRAIN.
//   - IDLE -> RUN on start with start_len!=0. Latches remaining=start_len and
//     rd_addr=start_addr; busy=1 from the next cycle.
//   - start with start_len==0: stay IDLE, pulse done next cycle, emit no words.
//   - RUN issues one read per cycle while remaining!=0 AND (fifo_count + in_flight) < 4.
//   - Issuing a read means: rd_addr advances by 1 (mod 2^ADDR_WIDTH; wraps
//     silently) and remaining decrements.
//   - The first read is the start_addr load itself.
//   - RUN -> DRAIN when the last read is issued.
//   - DRAIN -> IDLE on the handshake of the out_last word. done=1 in the following
//     cycle; busy=0 in the same cycle as done.
// - Read pipeline: address cycle N -> RAM data in cycle N+1 -> FIFO written at end
//   of N+1 -> out_valid in N+2.
//   - Timing: start sampled at edge 0; first out_valid during cycle 3 (after edge 3).
//   - in_flight (0..2) counts issued reads not yet written to the FIFO.
// - FIFO: 4 entries, each {last, data}.
//   - The credit rule guarantees it never overflows.
//   - Sustains 1 word/cycle while out_ready=1.
//   - out_* is driven from the FIFO head (registered, no combinational path from
//     rd_data).
// - Simultaneous FIFO write and read in the same cycle: count unchanged; both succeed.
// - out_ready low: out_valid/out_data/out_last hold stable until the handshake.
// - abort (any state):
//   - Next cycle: IDLE, FIFO emptied, out_valid=0, no done pulse, rd_addr holds.
//   - In-flight reads returning after abort are discarded.
//   - abort has priority over a same-cycle start.
// - start while busy: ignored, no side effects.
// STRUCTURE
// - Shared include: state encodings (IDLE/RUN/DRAIN) and FIFO depth constant (4).
// - Sub-module stream_fifo4:
//   - Synchronous 4-entry FIFO, width DATA_WIDTH+1, with count output.
//   - Clear input driven by abort.
// - Top holds the FSM, address/remaining counters and the in_flight counter.
// TESTING (bench instantiates dpram + reader; RAM preloaded mem[i]=i^8'hA5)
// - start_addr=0x10, len=4, out_ready=1: words A5^10..A5^13 on 4 consecutive cycles.
//   First word in cycle 3. out_last on the 4th word. done 1 cycle later.
// - start_addr=0xFE, len=4: words from addresses FE, FF, 00, 01 (wrap-around).
//   out_last on the word from address 01.
// - len=8, out_ready toggled randomly:
//   - All 8 words arrive in order, none lost or duplicated.
//   - Data held stable while stalled.
//   - Internal FIFO count never exceeds 4.
// - len=0: done pulses in cycle 1, out_valid stays 0, busy stays 0.
// - abort mid-burst (after 3 of 8 words):
//   - out_valid=0 next cycle, no done pulse.
//   - Subsequent burst at 0x40 returns only fresh data.
// - rst asserted mid-burst (asynchronous, between edges): all outputs at reset values
//   immediately. A second start during busy has no effect.

Source files
------------

// File: rtl/dpram_stream_reader_pkg.sv
// Shared constants for the dpram stream reader: FSM state encodings and the
// depth/width parameters of its 4-entry output FIFO.
package dpram_stream_reader_pkg;

  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_PTR_W = 2;
  localparam int FIFO_CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/dpram_stream_reader_stream_fifo4.sv
// Synchronous 4-entry FIFO with occupancy count and a synchronous clear.
// The head entry is read straight from storage registers.
module stream_fifo4
  import dpram_stream_reader_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  empty,
  output logic [FIFO_CNT_W-1:0] count
);

  logic [WIDTH-1:0]      mem_q [FIFO_DEPTH];
  logic [WIDTH-1:0]      mem_d [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_CNT_W-1:0] count_q, count_d;
  logic                  do_wr, do_rd;

  always_comb begin
    do_wr    = wr_en && (count_q != FIFO_CNT_W'(FIFO_DEPTH));
    do_rd    = rd_en && (count_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_wr) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + FIFO_PTR_W'(1);
      end
      if (do_rd) begin
        rd_ptr_d = rd_ptr_q + FIFO_PTR_W'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   count_d = count_q + FIFO_CNT_W'(1);
        2'b01:   count_d = count_q - FIFO_CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign empty   = (count_q == '0);
  assign count   = count_q;

endmodule

// File: rtl/dpram_stream_reader.sv
// Read-side controller for a same-clock dpram: bursts start_len words from
// start_addr and presents them as a valid/ready stream with a last flag.
module dpram_stream_reader
  import dpram_stream_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]  start_len,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready
);

  rd_state_e             state_q, state_d;
  logic                  start_pend_q, start_pend_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [LEN_WIDTH-1:0]  req_len_q, req_len_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic                  vld_p0_q, vld_p0_d, last_p0_q, last_p0_d;
  logic                  vld_p1_q, vld_p1_d, last_p1_q, last_p1_d;
  logic                  done_q, done_d;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic [DATA_WIDTH:0]   fifo_head;
  logic                  fifo_empty, pop, credit_ok;
  logic [1:0]            in_flight;

  // p0: address on the RAM port; p1: RAM data valid, written to the FIFO at the next edge
  assign in_flight = {1'b0, vld_p0_q} + {1'b0, vld_p1_q};
  assign credit_ok = ({1'b0, fifo_count} + {2'b00, in_flight}) < 4'(FIFO_DEPTH);
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d      = state_q;
    start_pend_d = 1'b0;
    req_addr_d   = req_addr_q;
    req_len_d    = req_len_q;
    rd_addr_d    = rd_addr_q;
    remaining_d  = remaining_q;
    vld_p0_d     = 1'b0;
    last_p0_d    = 1'b0;
    vld_p1_d     = vld_p0_q;
    last_p1_d    = last_p0_q;
    done_d       = 1'b0;
    if (abort) begin
      state_d  = ST_IDLE;
      vld_p1_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_pend_q) begin
            if (req_len_q == '0) begin
              done_d = 1'b1;
            end else begin
              // Loading the start address is itself the first read.
              rd_addr_d   = req_addr_q;
              remaining_d = req_len_q - LEN_WIDTH'(1);
              vld_p0_d    = 1'b1;
              last_p0_d   = (req_len_q == LEN_WIDTH'(1));
              state_d     = (req_len_q == LEN_WIDTH'(1)) ? ST_DRAIN : ST_RUN;
            end
          end else if (start) begin
            start_pend_d = 1'b1;
            req_addr_d   = start_addr;
            req_len_d    = start_len;
          end
        end
        ST_RUN: begin
          if ((remaining_q != '0) && credit_ok) begin
            rd_addr_d   = rd_addr_q + ADDR_WIDTH'(1);
            remaining_d = remaining_q - LEN_WIDTH'(1);
            vld_p0_d    = 1'b1;
            last_p0_d   = (remaining_q == LEN_WIDTH'(1));
            if (remaining_q == LEN_WIDTH'(1)) state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pop && fifo_head[DATA_WIDTH]) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      start_pend_q <= 1'b0;
      rd_addr_q    <= '0;
      remaining_q  <= '0;
      vld_p0_q     <= 1'b0;
      last_p0_q    <= 1'b0;
      vld_p1_q     <= 1'b0;
      last_p1_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_pend_q <= start_pend_d;
      rd_addr_q    <= rd_addr_d;
      remaining_q  <= remaining_d;
      vld_p0_q     <= vld_p0_d;
      last_p0_q    <= last_p0_d;
      vld_p1_q     <= vld_p1_d;
      last_p1_q    <= last_p1_d;
      done_q       <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    req_addr_q <= req_addr_d;
    req_len_q  <= req_len_d;
  end

  stream_fifo4 #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .clr    (abort),
    .wr_en  (vld_p1_q),
    .wr_data({last_p1_q, rd_data}),
    .rd_en  (pop),
    .rd_data(fifo_head),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign rd_addr   = rd_addr_q;
  assign out_valid = !fifo_empty;
  assign out_data  = out_valid ? fifo_head[DATA_WIDTH-1:0] : '0;
  assign out_last  = out_valid && fifo_head[DATA_WIDTH];

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Bench for dpram_stream_reader: a registered-read RAM model preloaded with
// mem[i] = i ^ 8'hA5 feeds the reader; directed bursts are checked word by word.
module tb_dpram_stream_reader;

  logic       clk = 1'b0;
  logic       rst, start, abort, out_ready;
  logic [7:0] start_addr;
  logic [8:0] start_len;
  logic       busy, done, out_valid, out_last;
  logic [7:0] rd_addr, out_data, ram_q;
  logic [7:0] mem [256];

  int   checks = 0, failures = 0;
  logic [7:0] got_d [32];
  logic       got_l [32];
  int   n_got, first_v, done_cyc, max_cnt, cnt_a, cnt_b, cnt_c;
  bit   busy_seen, finished;
  logic [7:0] held_addr;

  always #5 clk = ~clk;
  always @(posedge clk) ram_q <= mem[rd_addr];

  dpram_stream_reader #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .LEN_WIDTH(9)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .start_len(start_len), .abort(abort), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(ram_q), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_ready(out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Starts a burst and follows it cycle by cycle (cycle 0 = just after the start edge).
  task automatic do_burst(input logic [7:0] addr, input logic [8:0] len, input bit rnd,
                          input int abort_after, input int restart_cyc);
    bit         stalled = 1'b0;
    logic [7:0] hold_d = '0;
    logic       hold_l = 1'b0;
    n_got = 0; first_v = -1; done_cyc = -1; max_cnt = 0; busy_seen = 0; finished = 0;
    start = 1'b1; start_addr = addr; start_len = len; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      start = (cyc == restart_cyc);
      if (start) begin start_addr = 8'h80; start_len = 9'd2; end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (int'(dut.u_fifo.count) > max_cnt) max_cnt = int'(dut.u_fifo.count);
      if (busy) busy_seen = 1'b1;
      if (stalled) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_data", out_data, hold_d);
        chk("hold_last", out_last, hold_l);
      end
      if (out_valid && first_v < 0) first_v = cyc;
      if (out_valid && out_ready) begin
        if (n_got < 32) begin got_d[n_got] = out_data; got_l[n_got] = out_last; end
        n_got++;
      end
      stalled = out_valid && !out_ready; hold_d = out_data; hold_l = out_last;
      if (done) begin done_cyc = cyc; finished = 1'b1; break; end
      if (abort_after > 0 && n_got == abort_after) begin finished = 1'b1; break; end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("burst_end", finished, 1'b1);
  endtask

  // Counts valid/done/busy over a few idle cycles.
  task automatic watch_idle(input int ncyc);
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); #1;
      if (out_valid) cnt_a++;
      if (done) cnt_b++;
      if (busy) cnt_c++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    start_addr = '0; start_len = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rd_addr", rd_addr, 8'h00);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 8'h00);
    chk("rst_last", out_last, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic burst at 0x10, length 4, consumer always ready
    do_burst(8'h10, 9'd4, 1'b0, 0, -1);
    chk("t1_first_cyc", first_v, 3);
    chk("t1_nwords", n_got, 4);
    chk("t1_w0", got_d[0], 8'hB5);
    chk("t1_w1", got_d[1], 8'hB4);
    chk("t1_w2", got_d[2], 8'hB7);
    chk("t1_w3", got_d[3], 8'hB6);
    chk("t1_last_early", {got_l[0], got_l[1], got_l[2]}, 3'b000);
    chk("t1_last", got_l[3], 1'b1);
    chk("t1_done_cyc", done_cyc, 7);
    chk("t1_busy_at_done", busy, 1'b0);
    @(posedge clk); #1;
    chk("t1_done_pulse", done, 1'b0);

    // Address wrap FE, FF, 00, 01
    do_burst(8'hFE, 9'd4, 1'b0, 0, -1);
    chk("t2_nwords", n_got, 4);
    chk("t2_w0", got_d[0], 8'h5B);
    chk("t2_w1", got_d[1], 8'h5A);
    chk("t2_w2", got_d[2], 8'hA5);
    chk("t2_w3", got_d[3], 8'hA4);
    chk("t2_last", {got_l[0], got_l[1], got_l[2], got_l[3]}, 4'b0001);

    // Length 8 with random back-pressure
    do_burst(8'h20, 9'd8, 1'b1, 0, -1);
    chk("t3_nwords", n_got, 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t3_w%0d", i), got_d[i], (8'h20 + 8'(i)) ^ 8'hA5);
      chk($sformatf("t3_l%0d", i), got_l[i], (i == 7) ? 1'b1 : 1'b0);
    end
    chk("t3_fifo_max_ok", (max_cnt <= 4) ? 1'b1 : 1'b0, 1'b1);

    // Zero-length burst
    do_burst(8'h00, 9'd0, 1'b0, 0, -1);
    chk("t4_done_cyc", done_cyc, 1);
    chk("t4_no_words", n_got, 0);
    chk("t4_no_valid", first_v, -1);
    chk("t4_no_busy", busy_seen, 1'b0);

    // Abort after 3 of 8 words, then a fresh burst at 0x40
    do_burst(8'h30, 9'd8, 1'b0, 3, -1);
    chk("t5_nwords", n_got, 3);
    chk("t5_w0", got_d[0], 8'h95);
    chk("t5_w2", got_d[2], 8'h97);
    @(posedge clk); #1;
    out_ready = 1'b0; abort = 1'b1; held_addr = rd_addr;
    chk("t5_valid_before", out_valid, 1'b1);
    @(posedge clk); #1;
    abort = 1'b0;
    chk("t5_valid_after", out_valid, 1'b0);
    chk("t5_busy_after", busy, 1'b0);
    chk("t5_addr_hold", rd_addr, held_addr);
    chk("t5_done_after", done, 1'b0);
    watch_idle(6);
    chk("t5_idle_valid", cnt_a, 0);
    chk("t5_idle_done", cnt_b, 0);
    do_burst(8'h40, 9'd4, 1'b0, 0, -1);
    chk("t5_fresh_n", n_got, 4);
    chk("t5_fresh_w0", got_d[0], 8'hE5);
    chk("t5_fresh_w1", got_d[1], 8'hE4);
    chk("t5_fresh_w2", got_d[2], 8'hE7);
    chk("t5_fresh_w3", got_d[3], 8'hE6);
    chk("t5_fresh_done", done_cyc, 7);

    // Second start while busy is ignored
    do_burst(8'h10, 9'd4, 1'b0, 0, 2);
    chk("t6_nwords", n_got, 4);
    chk("t6_w0", got_d[0], 8'hB5);
    chk("t6_w3", got_d[3], 8'hB6);
    watch_idle(8);
    chk("t6_idle_valid", cnt_a, 0);
    chk("t6_idle_done", cnt_b, 0);
    chk("t6_idle_busy", cnt_c, 0);

    // Asynchronous reset mid-burst
    start = 1'b1; start_addr = 8'h50; start_len = 9'd8; out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    chk("t7_valid_pre", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("t7_busy", busy, 1'b0);
    chk("t7_valid", out_valid, 1'b0);
    chk("t7_data", out_data, 8'h00);
    chk("t7_last", out_last, 1'b0);
    chk("t7_rd_addr", rd_addr, 8'h00);
    chk("t7_done", done, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_burst(8'h60, 9'd2, 1'b0, 0, -1);
    chk("t7_after_n", n_got, 2);
    chk("t7_after_w0", got_d[0], 8'hC5);
    chk("t7_after_w1", got_d[1], 8'hC4);
    chk("t7_after_last", got_l[1], 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
